// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes, baud divider helpers.
// Used by uart_tx_core and the matching receiver.
package uart_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_START  = S_START,
      ST_DATA   = S_DATA,
      ST_PARITY = S_PARITY,
      ST_STOP   = S_STOP
   } uart_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int calc_cnt_w(input int baud_div);
      return (baud_div < 2) ? 1 : $clog2(baud_div);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-cell timer: counts 0..BAUD_DIV-1 while enabled, pulses tick_o on the last count.
// Held at zero whenever disabled so every enabled run starts on a fresh cell.
module uart_baud_tick #(
   parameter int BAUD_DIV = 434,
   parameter int CNT_W    = 9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic tick_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last_cnt;

   assign last_cnt = (cnt_q == CNT_W'(BAUD_DIV - 1));
   assign tick_o   = en_i && last_cnt;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (last_cnt) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: LSB-first serialiser with optional parity and 1 or 2 stop bits.
// tx and tx_busy are registered; strobes while busy are dropped.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] write_data,
   input  logic       write_en,
   output logic       tx_busy,
   output logic       tx
);

   localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W    = calc_cnt_w(BAUD_DIV);

   generate
      if (PARITY < PAR_NONE || PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2 ||
          BAUD_DIV < 2) begin : g_bad_param
         $error("uart_tx_core: illegal PARITY, STOP_BITS or BAUD_DIV");
      end
   endgenerate

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;
   logic        par_q, par_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        tick;

   uart_baud_tick #(
      .BAUD_DIV (BAUD_DIV),
      .CNT_W    (CNT_W)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (state_q != ST_IDLE),
      .tick_o (tick)
   );

   // tx_d is the line level for the state being entered, so tx is glitch-free and registered.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      unique case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (write_en) begin
               shift_d = write_data;
               par_d   = (PARITY == PAR_ODD) ? ~(^write_data) : ^write_data;
               bit_d   = 3'd0;
               state_d = ST_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d = 3'd0;
                  if (PARITY != PAR_NONE) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               bit_d   = 3'd0;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (bit_q == 3'(STOP_BITS - 1)) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- UART transmitter that sits directly downstream of the UART data generator.
- Accepts a one-cycle write strobe with a byte and serialises it LSB-first as 8N1 by default; optional parity and 2 stop bits.
- Drives tx_busy, whose falling edge is the generator's cue to issue the next byte.
- Output tx goes straight to the board UART pin.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate. BAUD_DIV = CLK_FREQ/BAUD_RATE with integer truncation; 434 at the defaults.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; the block has one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- write_data  in  8  byte to send; sampled only on an accepted strobe.
- write_en  in  1  single-cycle write strobe.
- tx_busy  out  1  high from the cycle after acceptance until the frame ends.
- tx  out  1  serial line; idles high.

Behaviour:
- Reset (rst_n low at a clk edge):
  - tx = 1, tx_busy = 0, state = IDLE, baud counter = 0, bit index = 0, shift register = 0.
  - Reset mid-frame aborts the frame immediately: tx is high and busy is low on the next edge; no partial stop bit.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - write_en = 1 latches write_data into the shift register.
  - Computes the parity bit: even = XOR of the data bits; odd = inverted XOR.
  - Next edge: state = START, tx = 0, tx_busy = 1, baud counter = 0.
  - Latency: strobe at edge N gives tx low and busy high after edge N+1.
- Baud counter:
  - Counts 0..BAUD_DIV-1 in every non-IDLE state.
  - Each bit cell lasts exactly BAUD_DIV clocks.
  - The state or bit advance happens on the cycle the counter equals BAUD_DIV-1; the counter wraps to 0 on that cycle.
  - Counter width = clog2(BAUD_DIV).
- START: holds tx = 0 for one cell, then goes to DATA with bit index 0.
- DATA:
  - tx = shift[0]; the register shifts right at the end of each cell.
  - After bit index 7 completes: go to PARITY if PARITY != 0, else STOP.
- PARITY: tx = stored parity bit for one cell, then STOP.
- STOP:
  - tx = 1 for STOP_BITS cells.
  - At the end of the last cell: state = IDLE and tx_busy = 0 on the same edge.
  - Total frame length = BAUD_DIV × (10 + (PARITY != 0) + (STOP_BITS − 1)) clocks.
- Back-to-back frames:
  - write_en in the first IDLE cycle after busy falls is accepted, so there is no dead cell.
  - Minimum spacing between frames is one clk.
- write_en while busy: ignored. No queueing, data is not corrupted, no error flag.
- write_data is not required to be stable after the strobe cycle.
- Illegal parameter values (PARITY > 2, STOP_BITS not 1 or 2, BAUD_DIV < 2) are rejected by an elaboration-time check.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (localparams for IDLE/START/DATA/PARITY/STOP);
  - the parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN);
  - a constant function computing BAUD_DIV and the counter width.
- The package is shared with the future uart_rx_core.
- One natural sub-module, uart_baud_tick: a counter with enable that emits a one-cycle tick at BAUD_DIV-1 and clears when disabled. The receiver reuses it with a half-cell offset.

Test Plan:
All scenarios use CLK_FREQ = 1_000_000 and BAUD_RATE = 100_000 (BAUD_DIV = 10), with PARITY = 0 and STOP_BITS = 1 unless stated.
1. Reset, then write_en with 0x55 -> busy rises one clk later; tx shows 0,1,0,1,0,1,0,1,0,1, each held exactly 10 clks; busy falls after 100 clks.
2. PARITY = 2, byte 0x07 -> parity cell = 1. PARITY = 1, same byte -> parity cell = 0. Frame lasts 110 clks.
3. STOP_BITS = 2, byte 0xA0 -> tx high for 20 clks after bit 7; busy falls at 110 clks.
4. write_en with 0x33 at clk 40 of a 0x55 frame -> ignored; line carries only 0x55. Re-strobe 0x33 the cycle busy falls -> start bit begins next edge, with no gap cell.
5. rst_n low at clk 37 of a frame -> tx = 1 and busy = 0 on the next edge. A new strobe after release yields a clean frame.
6. Drive the uart_data_gen pair with write_max_num = 2 -> two frames are sent back to back. The second starts within 2 clks of the first busy falling edge.
